tlk2711_axil_reg_bridge: RTL and testbench
==========================================

# tlk2711_axil_reg_bridge

AXI4-Lite slave that turns PS register accesses into the single-cycle register bus driven into the TLK2711 register manager. It owns the other end of that bus: it generates the write strobe, address and data, and the read strobe and address. It then captures the returned 64-bit read data. The PS master port is 32 bits wide, so each 64-bit register appears as two 32-bit words; the bridge assembles writes and splits reads.

## Interface
Parameters:
- AXIL_ADDR_WIDTH, 16, AXI4-Lite byte address width (≥16)
- RD_LATENCY, 1, cycles from o_reg_ren to valid i_reg_rdata (1..4)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  sole clock
- rst  in  1  synchronous active-high reset
- s_axil_awvalid / s_axil_awready  in / out  1  write address handshake
- s_axil_awaddr  in  AXIL_ADDR_WIDTH  write byte address
- s_axil_wvalid / s_axil_wready  in / out  1  write data handshake
- s_axil_wdata  in  32  write data
- s_axil_wstrb  in  4  byte strobes
- s_axil_bvalid / s_axil_bready  out / in  1  write response handshake
- s_axil_bresp  out  2  write response, 00 OKAY / 10 SLVERR
- s_axil_arvalid / s_axil_arready  in / out  1  read address handshake
- s_axil_araddr  in  AXIL_ADDR_WIDTH  read byte address
- s_axil_rvalid / s_axil_rready  out / in  1  read data handshake
- s_axil_rdata  out  32  read data
- s_axil_rresp  out  2  read response
- o_reg_wen  out  1  register write strobe, one-cycle pulse
- o_reg_waddr  out  16  register byte address, {addr[15:3],3'b000}
- o_reg_wdata  out  64  register write data
- o_reg_ren  out  1  register read strobe, one-cycle pulse
- o_reg_raddr  out  16  register byte address, {addr[15:3],3'b000}
- i_reg_rdata  in  64  register read data

## Operation
- **Word mapping:** addr[2]=0 selects the low word [31:0] and addr[2]=1 selects the high word [63:32]. Bits above 15 are ignored.
- **Error check:** addr[1:0]≠0 is an error. On writes, wstrb≠4'hF is also an error.
- **States:** IDLE, WR_EXEC, WR_RESP, RD_ISSUE, RD_WAIT, RD_RESP.
- **IDLE, write capture:** awready and wready are asserted independently until each channel is captured, so AW and W may arrive in either order or in the same cycle.
- **IDLE, read capture:** arready is asserted only while no write channel is partially captured.
- **Arbitration:** when a complete write (AW+W) and an AR are both pending in IDLE, a one-bit last_served flag picks the side not served last. The flag resets to "read", so write wins first.
- **Low-word write:** wdata is stored in a 32-bit shadow register and bresp=OKAY. No o_reg_wen is issued.
- **High-word write:** o_reg_wen pulses with wdata={s_axil_wdata, shadow}. The shadow is not cleared afterwards.
- **Write errors:** any error gives bresp=SLVERR. No o_reg_wen is issued and the shadow is unchanged.
- **WR_EXEC:** one cycle, drives the o_reg_wen pulse if applicable. Next state is WR_RESP.
- **WR_RESP:** bvalid is held until bready. Next state is IDLE.
- **RD_ISSUE:** o_reg_ren pulses. Next state is RD_WAIT.
- **RD_WAIT:** counts RD_LATENCY cycles, then captures i_reg_rdata[63:32] or [31:0] per addr[2]. Next state is RD_RESP.
- **Read errors:** a misaligned read skips RD_ISSUE/RD_WAIT and goes straight to RD_RESP with rdata=0 and rresp=SLVERR.
- **RD_RESP:** rvalid is held until rready; rdata and rresp stay stable while rvalid is high. Next state is IDLE.
- **Ordering:** exactly one transaction is outstanding at a time.

## Timing
- **Reset:** all ready/valid outputs are 0; bresp=rresp=00; rdata=0; o_reg_wen=o_reg_ren=0; o_reg_waddr=o_reg_raddr=0; o_reg_wdata=0; shadow=0; state=IDLE; last_served=read.
- **Ready after reset:** awready, wready and arready rise in the first cycle after rst deasserts.
- **Write latency:** if the last of AW/W handshakes in cycle N, o_reg_wen is high in N+1 and bvalid rises in N+2. o_reg_waddr/o_reg_wdata are valid with o_reg_wen and hold until the next write.
- **Read latency:** AR handshakes in cycle N, o_reg_ren is high in N+1, data is sampled in N+1+RD_LATENCY, and rvalid rises in N+2+RD_LATENCY.
- **Bus pulses:** o_reg_wen and o_reg_ren are never high in the same cycle and are never high for two consecutive cycles.
- **Reset mid-transaction:** rst returns the bridge to IDLE next cycle and drops any pending b/r response; no strobe is issued in the reset cycle.

## Structure
- **Shared package** tlk2711_pkg holds:
  - the state encoding;
  - RESP_OKAY=2'b00 and RESP_SLVERR=2'b10;
  - the word-select bit index (2) and alignment mask.
- **Sub-module:** one, tlk2711_axil_wr_capture. It holds the independent AW/W capture registers with their per-channel ready and full flags, and presents a single "write pending" to the main FSM.

## Test plan
- **Paired write:** write 0x1122_3344 to 0x0010, then 0xAABB_CCDD to 0x0014 → no strobe after the first write; one o_reg_wen with waddr=0x0010 and wdata=0xAABBCCDD_11223344; both bresp=OKAY; bvalid at N+2.
- **Split read:** with i_reg_rdata modelled as 0x0123_4567_89AB_CDEF at RD_LATENCY=1, read 0x0008 then 0x000C → rdata 0x89ABCDEF then 0x01234567; each read gives one o_reg_ren with raddr=0x0008; rvalid at N+3.
- **W before AW, with backpressure:** present W three cycles before AW and hold bready low for 5 cycles → a single o_reg_wen; bvalid held high with stable bresp until bready.
- **Errors:** write to 0x0016 and write with wstrb=4'h3 → SLVERR on both, no o_reg_wen, shadow unchanged; read of 0x0001 → SLVERR, rdata=0, no o_reg_ren.
- **Simultaneous write and read:** complete write and AR presented in the same cycle after reset → write served first, then the read; repeat the collision → read served first.
- **Reset mid-read:** assert rst during RD_WAIT → no rvalid; all outputs at reset values; the next read completes normally.

Source files
------------

// File: rtl/tlk2711_pkg.sv
// Shared definitions for the TLK2711 AXI4-Lite register bridge:
// FSM encoding, AXI response codes and register address helpers.
package tlk2711_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_EXEC,
        ST_WR_RESP,
        ST_RD_ISSUE,
        ST_RD_WAIT,
        ST_RD_RESP
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Byte-address bit choosing the high (1) or low (0) 32-bit half.
    localparam int WORD_SEL_BIT = 2;

    // Byte-address bits that must be zero for a legal word access.
    localparam logic [1:0] ALIGN_MASK = 2'b11;

    // 64-bit register byte address seen by the register manager.
    function automatic logic [15:0] reg_addr(input logic [15:0] a);
        return {a[15:3], 3'b000};
    endfunction

    function automatic logic misaligned(input logic [1:0] lsb);
        return |(lsb & ALIGN_MASK);
    endfunction

endpackage

// File: rtl/tlk2711_axil_wr_capture.sv
// Independent AW/W channel capture. Each channel is accepted once,
// and a complete write is reported as pending (including bypass).
module tlk2711_axil_wr_capture #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              consume,
    input  logic              awvalid,
    output logic              awready,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic              wvalid,
    output logic              wready,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wstrb,
    output logic              pending,
    output logic              partial,
    output logic [ADDR_W-1:0] addr,
    output logic [31:0]       data,
    output logic [3:0]        strb
);

    logic              aw_full;
    logic              w_full;
    logic              aw_hs;
    logic              w_hs;
    logic [ADDR_W-1:0] aw_addr_q;
    logic [31:0]       w_data_q;
    logic [3:0]        w_strb_q;

    assign awready = enable && !aw_full;
    assign wready  = enable && !w_full;
    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;

    assign pending = enable && (aw_full || aw_hs) && (w_full || w_hs);
    assign partial = aw_full ^ w_full;

    assign addr = aw_full ? aw_addr_q : awaddr;
    assign data = w_full ? w_data_q : wdata;
    assign strb = w_full ? w_strb_q : wstrb;

    // Hold each channel until the FSM consumes the complete write.
    always_ff @(posedge clk) begin
        if (rst) begin
            aw_full   <= 1'b0;
            w_full    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
        end else begin
            if (consume) begin
                aw_full <= 1'b0;
                w_full  <= 1'b0;
            end else begin
                if (aw_hs) aw_full <= 1'b1;
                if (w_hs)  w_full  <= 1'b1;
            end
            if (aw_hs) aw_addr_q <= awaddr;
            if (w_hs) begin
                w_data_q <= wdata;
                w_strb_q <= wstrb;
            end
        end
    end

endmodule

// File: rtl/tlk2711_axil_reg_bridge.sv
// AXI4-Lite slave bridging 32-bit PS accesses onto the 64-bit
// single-cycle TLK2711 register bus (write assembly, read split).
module tlk2711_axil_reg_bridge
    import tlk2711_pkg::*;
#(
    parameter int AXIL_ADDR_WIDTH = 16,
    parameter int RD_LATENCY      = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_axil_awvalid,
    output logic                       s_axil_awready,
    input  logic [AXIL_ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic                       s_axil_wvalid,
    output logic                       s_axil_wready,
    input  logic [31:0]                s_axil_wdata,
    input  logic [3:0]                 s_axil_wstrb,
    output logic                       s_axil_bvalid,
    input  logic                       s_axil_bready,
    output logic [1:0]                 s_axil_bresp,
    input  logic                       s_axil_arvalid,
    output logic                       s_axil_arready,
    input  logic [AXIL_ADDR_WIDTH-1:0] s_axil_araddr,
    output logic                       s_axil_rvalid,
    input  logic                       s_axil_rready,
    output logic [31:0]                s_axil_rdata,
    output logic [1:0]                 s_axil_rresp,
    output logic                       o_reg_wen,
    output logic [15:0]                o_reg_waddr,
    output logic [63:0]                o_reg_wdata,
    output logic                       o_reg_ren,
    output logic [15:0]                o_reg_raddr,
    input  logic [63:0]                i_reg_rdata
);

    localparam logic [2:0] LAT = 3'(RD_LATENCY);

    state_t state;
    state_t state_d;

    logic                       idle;
    logic                       wr_pend;
    logic                       wr_partial;
    logic                       wr_grant;
    logic                       rd_grant;
    logic                       last_wr;
    logic                       wr_err;
    logic                       wr_hi;
    logic                       rd_err;
    logic                       rd_hi;
    logic                       wen_q;
    logic [AXIL_ADDR_WIDTH-1:0] wr_addr;
    logic [31:0]                wr_data;
    logic [3:0]                 wr_strb;
    logic [31:0]                shadow;
    logic [2:0]                 cnt;

    assign idle = (state == ST_IDLE) && !rst;

    tlk2711_axil_wr_capture #(
        .ADDR_W (AXIL_ADDR_WIDTH)
    ) u_wr_capture (
        .clk     (clk),
        .rst     (rst),
        .enable  (idle),
        .consume (wr_grant),
        .awvalid (s_axil_awvalid),
        .awready (s_axil_awready),
        .awaddr  (s_axil_awaddr),
        .wvalid  (s_axil_wvalid),
        .wready  (s_axil_wready),
        .wdata   (s_axil_wdata),
        .wstrb   (s_axil_wstrb),
        .pending (wr_pend),
        .partial (wr_partial),
        .addr    (wr_addr),
        .data    (wr_data),
        .strb    (wr_strb)
    );

    // A pending write blocks AR unless the write side was served last.
    assign s_axil_arready = idle && !wr_partial && !(wr_pend && !last_wr);
    assign rd_grant = s_axil_arvalid && s_axil_arready;
    assign wr_grant = wr_pend && !rd_grant;

    assign wr_err = misaligned(wr_addr[1:0]) || (wr_strb != 4'hF);
    assign wr_hi  = wr_addr[WORD_SEL_BIT];
    assign rd_err = misaligned(s_axil_araddr[1:0]);

    assign o_reg_wen = wen_q && !rst;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_d;
    end

    // Next-state logic and state-decoded handshake outputs.
    always_comb begin
        state_d       = state;
        s_axil_bvalid = 1'b0;
        s_axil_rvalid = 1'b0;
        o_reg_ren     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (wr_grant)      state_d = ST_WR_EXEC;
                else if (rd_grant) state_d = rd_err ? ST_RD_RESP : ST_RD_ISSUE;
            end
            ST_WR_EXEC: state_d = ST_WR_RESP;
            ST_WR_RESP: begin
                s_axil_bvalid = !rst;
                if (s_axil_bready) state_d = ST_IDLE;
            end
            ST_RD_ISSUE: begin
                o_reg_ren = !rst;
                state_d   = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (cnt == LAT) state_d = ST_RD_RESP;
            end
            ST_RD_RESP: begin
                s_axil_rvalid = !rst;
                if (s_axil_rready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Register-bus datapath, shadow word, responses and arbitration flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wen_q        <= 1'b0;
            o_reg_waddr  <= '0;
            o_reg_wdata  <= '0;
            o_reg_raddr  <= '0;
            shadow       <= '0;
            s_axil_bresp <= RESP_OKAY;
            s_axil_rresp <= RESP_OKAY;
            s_axil_rdata <= '0;
            rd_hi        <= 1'b0;
            cnt          <= '0;
            last_wr      <= 1'b0;
        end else begin
            wen_q <= 1'b0;
            if (wr_pend && s_axil_arvalid && !wr_partial) begin
                last_wr <= wr_grant;
            end
            if (wr_grant) begin
                s_axil_bresp <= wr_err ? RESP_SLVERR : RESP_OKAY;
                if (!wr_err && wr_hi) begin
                    wen_q       <= 1'b1;
                    o_reg_waddr <= reg_addr(wr_addr[15:0]);
                    o_reg_wdata <= {wr_data, shadow};
                end else if (!wr_err) begin
                    shadow <= wr_data;
                end
            end
            if (rd_grant) begin
                rd_hi <= s_axil_araddr[WORD_SEL_BIT];
                if (rd_err) begin
                    s_axil_rdata <= '0;
                    s_axil_rresp <= RESP_SLVERR;
                end else begin
                    s_axil_rresp <= RESP_OKAY;
                    o_reg_raddr  <= reg_addr(s_axil_araddr[15:0]);
                end
            end
            if (state == ST_RD_ISSUE) cnt <= 3'd1;
            if (state == ST_RD_WAIT) begin
                if (cnt == LAT) begin
                    s_axil_rdata <= rd_hi ? i_reg_rdata[63:32] : i_reg_rdata[31:0];
                end else begin
                    cnt <= cnt + 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_tlk2711_axil_reg_bridge.sv
// Directed self-checking bench for tlk2711_axil_reg_bridge.
// Register manager modelled with a one-cycle read latency.
module tb_tlk2711_axil_reg_bridge;

    localparam logic [63:0] REG_VAL = 64'h0123_4567_89AB_CDEF;
    localparam logic [1:0]  OKAY    = 2'b00;
    localparam logic [1:0]  SLVERR  = 2'b10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_axil_awvalid = 1'b0;
    logic        s_axil_awready;
    logic [15:0] s_axil_awaddr = '0;
    logic        s_axil_wvalid = 1'b0;
    logic        s_axil_wready;
    logic [31:0] s_axil_wdata = '0;
    logic [3:0]  s_axil_wstrb = '0;
    logic        s_axil_bvalid;
    logic        s_axil_bready = 1'b0;
    logic [1:0]  s_axil_bresp;
    logic        s_axil_arvalid = 1'b0;
    logic        s_axil_arready;
    logic [15:0] s_axil_araddr = '0;
    logic        s_axil_rvalid;
    logic        s_axil_rready = 1'b0;
    logic [31:0] s_axil_rdata;
    logic [1:0]  s_axil_rresp;
    logic        o_reg_wen;
    logic [15:0] o_reg_waddr;
    logic [63:0] o_reg_wdata;
    logic        o_reg_ren;
    logic [15:0] o_reg_raddr;
    logic [63:0] i_reg_rdata;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int wen_cnt = 0;
    int ren_cnt = 0;
    int wen_cyc = -1;
    int ren_cyc = -1;
    int pulse_bad = 0;
    logic [15:0] wen_addr = '0;
    logic [63:0] wen_data = '0;
    logic [15:0] ren_addr = '0;
    logic prev_wen = 1'b0;
    logic prev_ren = 1'b0;
    logic ren_d = 1'b0;

    tlk2711_axil_reg_bridge #(
        .AXIL_ADDR_WIDTH (16),
        .RD_LATENCY      (1)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .s_axil_awvalid (s_axil_awvalid),
        .s_axil_awready (s_axil_awready),
        .s_axil_awaddr  (s_axil_awaddr),
        .s_axil_wvalid  (s_axil_wvalid),
        .s_axil_wready  (s_axil_wready),
        .s_axil_wdata   (s_axil_wdata),
        .s_axil_wstrb   (s_axil_wstrb),
        .s_axil_bvalid  (s_axil_bvalid),
        .s_axil_bready  (s_axil_bready),
        .s_axil_bresp   (s_axil_bresp),
        .s_axil_arvalid (s_axil_arvalid),
        .s_axil_arready (s_axil_arready),
        .s_axil_araddr  (s_axil_araddr),
        .s_axil_rvalid  (s_axil_rvalid),
        .s_axil_rready  (s_axil_rready),
        .s_axil_rdata   (s_axil_rdata),
        .s_axil_rresp   (s_axil_rresp),
        .o_reg_wen      (o_reg_wen),
        .o_reg_waddr    (o_reg_waddr),
        .o_reg_wdata    (o_reg_wdata),
        .o_reg_ren      (o_reg_ren),
        .o_reg_raddr    (o_reg_raddr),
        .i_reg_rdata    (i_reg_rdata)
    );

    always #5 clk = ~clk;

    // Cycle counter and register-manager read latency model.
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        ren_d <= o_reg_ren;
    end

    assign i_reg_rdata = ren_d ? REG_VAL : 64'hDEAD_BEEF_DEAD_BEEF;

    // Strobe monitor: counts pulses and flags overlap or back-to-back.
    always @(negedge clk) begin
        if (o_reg_wen) begin
            wen_cnt++;
            wen_cyc  = cyc;
            wen_addr = o_reg_waddr;
            wen_data = o_reg_wdata;
        end
        if (o_reg_ren) begin
            ren_cnt++;
            ren_cyc  = cyc;
            ren_addr = o_reg_raddr;
        end
        if ((o_reg_wen && o_reg_ren) || (o_reg_wen && prev_wen) ||
            (o_reg_ren && prev_ren)) pulse_bad++;
        prev_wen = o_reg_wen;
        prev_ren = o_reg_ren;
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input logic [15:0] a, input logic [31:0] d,
                             input logic [3:0] s, input int aw_delay,
                             input int b_hold, output logic [1:0] resp,
                             output int hs_c, output int b_c);
        bit awd;
        bit wd;
        int unstable;
        awd = 0;
        wd = 0;
        unstable = 0;
        hs_c = -1;
        b_c = -1;
        resp = 2'b11;
        @(negedge clk);
        s_axil_wvalid = 1'b1;
        s_axil_wdata  = d;
        s_axil_wstrb  = s;
        s_axil_awaddr = a;
        for (int i = 0; i < 40 && !(awd && wd); i++) begin
            if (i >= aw_delay && !awd) s_axil_awvalid = 1'b1;
            #1;
            if (s_axil_awvalid && s_axil_awready) awd = 1;
            if (s_axil_wvalid && s_axil_wready) wd = 1;
            if (awd && wd) hs_c = cyc;
            @(negedge clk);
            if (awd) s_axil_awvalid = 1'b0;
            if (wd) s_axil_wvalid = 1'b0;
        end
        chk("wr_handshake_timeout", {awd, wd}, 2'b11);
        for (int i = 0; i < 40 && !s_axil_bvalid; i++) @(negedge clk);
        chk("wr_bvalid_timeout", s_axil_bvalid, 1'b1);
        b_c = cyc;
        resp = s_axil_bresp;
        repeat (b_hold) begin
            @(negedge clk);
            if (!s_axil_bvalid || s_axil_bresp !== resp) unstable++;
        end
        if (b_hold > 0) chk("wr_b_hold_stable", unstable, 0);
        s_axil_bready = 1'b1;
        @(negedge clk);
        s_axil_bready = 1'b0;
    endtask

    task automatic axi_read(input logic [15:0] a, output logic [31:0] data,
                            output logic [1:0] resp, output int hs_c,
                            output int r_c);
        bit done;
        done = 0;
        hs_c = -1;
        r_c = -1;
        @(negedge clk);
        s_axil_arvalid = 1'b1;
        s_axil_araddr  = a;
        for (int i = 0; i < 40 && !done; i++) begin
            #1;
            if (s_axil_arvalid && s_axil_arready) begin
                done = 1;
                hs_c = cyc;
            end
            @(negedge clk);
            if (done) s_axil_arvalid = 1'b0;
        end
        chk("rd_handshake_timeout", done, 1'b1);
        for (int i = 0; i < 40 && !s_axil_rvalid; i++) @(negedge clk);
        chk("rd_rvalid_timeout", s_axil_rvalid, 1'b1);
        r_c = cyc;
        data = s_axil_rdata;
        resp = s_axil_rresp;
        s_axil_rready = 1'b1;
        @(negedge clk);
        s_axil_rready = 1'b0;
    endtask

    logic [1:0]  bresp_a;
    logic [1:0]  rresp_a;
    logic [31:0] rdata_a;
    int hs_w;
    int hs_r;
    int b_cy;
    int r_cy;
    int n0;
    int m0;
    int rv_seen;

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready", {s_axil_awready, s_axil_wready, s_axil_arready}, 3'b000);
        chk("rst_valid", {s_axil_bvalid, s_axil_rvalid}, 2'b00);
        chk("rst_strobes", {o_reg_wen, o_reg_ren}, 2'b00);
        chk("rst_addrs", {o_reg_waddr, o_reg_raddr}, 32'h0);
        chk("rst_wdata", o_reg_wdata, 64'h0);
        chk("rst_rdata_resp", {s_axil_rdata, s_axil_bresp, s_axil_rresp}, 36'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", {s_axil_awready, s_axil_wready, s_axil_arready}, 3'b111);

        // Paired low/high write.
        n0 = wen_cnt;
        axi_write(16'h0010, 32'h1122_3344, 4'hF, 0, 0, bresp_a, hs_w, b_cy);
        #2;
        chk("lo_bresp", bresp_a, OKAY);
        chk("lo_no_wen", wen_cnt, n0);
        chk("lo_b_latency", b_cy - hs_w, 2);
        axi_write(16'h0014, 32'hAABB_CCDD, 4'hF, 0, 0, bresp_a, hs_w, b_cy);
        #2;
        chk("hi_bresp", bresp_a, OKAY);
        chk("hi_wen_count", wen_cnt, n0 + 1);
        chk("hi_waddr", wen_addr, 16'h0010);
        chk("hi_wdata", wen_data, 64'hAABB_CCDD_1122_3344);
        chk("hi_wen_latency", wen_cyc - hs_w, 1);
        chk("hi_b_latency", b_cy - hs_w, 2);

        // Split read of one 64-bit register.
        m0 = ren_cnt;
        axi_read(16'h0008, rdata_a, rresp_a, hs_r, r_cy);
        #2;
        chk("rd_lo_data", rdata_a, 32'h89AB_CDEF);
        chk("rd_lo_resp", rresp_a, OKAY);
        chk("rd_lo_ren_count", ren_cnt, m0 + 1);
        chk("rd_lo_raddr", ren_addr, 16'h0008);
        chk("rd_lo_ren_latency", ren_cyc - hs_r, 1);
        chk("rd_lo_rvalid_latency", r_cy - hs_r, 3);
        axi_read(16'h000C, rdata_a, rresp_a, hs_r, r_cy);
        #2;
        chk("rd_hi_data", rdata_a, 32'h0123_4567);
        chk("rd_hi_ren_count", ren_cnt, m0 + 2);
        chk("rd_hi_raddr", ren_addr, 16'h0008);
        chk("rd_hi_rvalid_latency", r_cy - hs_r, 3);

        // W three cycles ahead of AW, bready held off five cycles.
        n0 = wen_cnt;
        axi_write(16'h0014, 32'hCAFE_F00D, 4'hF, 3, 5, bresp_a, hs_w, b_cy);
        #2;
        chk("wfirst_wen_count", wen_cnt, n0 + 1);
        chk("wfirst_wdata", wen_data, 64'hCAFE_F00D_1122_3344);
        chk("wfirst_wen_latency", wen_cyc - hs_w, 1);
        chk("wfirst_bresp", bresp_a, OKAY);

        // Error cases.
        n0 = wen_cnt;
        axi_write(16'h0016, 32'h5555_5555, 4'hF, 0, 0, bresp_a, hs_w, b_cy);
        #2;
        chk("err_misaligned_bresp", bresp_a, SLVERR);
        axi_write(16'h0010, 32'h6666_6666, 4'h3, 0, 0, bresp_a, hs_w, b_cy);
        #2;
        chk("err_strb_bresp", bresp_a, SLVERR);
        chk("err_no_wen", wen_cnt, n0);
        axi_write(16'h0014, 32'h7777_7777, 4'hF, 0, 0, bresp_a, hs_w, b_cy);
        #2;
        chk("err_shadow_kept", wen_data, 64'h7777_7777_1122_3344);
        m0 = ren_cnt;
        axi_read(16'h0001, rdata_a, rresp_a, hs_r, r_cy);
        #2;
        chk("err_rd_resp", rresp_a, SLVERR);
        chk("err_rd_data", rdata_a, 32'h0);
        chk("err_rd_no_ren", ren_cnt, m0);
        chk("err_rd_latency", r_cy - hs_r, 1);

        // Write/read collision: write wins first, read wins next time.
        fork
            axi_write(16'h0014, 32'h9999_9999, 4'hF, 0, 0, bresp_a, hs_w, b_cy);
            axi_read(16'h0008, rdata_a, rresp_a, hs_r, r_cy);
        join
        #2;
        chk("coll1_write_first", wen_cyc < ren_cyc, 1'b1);
        chk("coll1_wdata", wen_data, 64'h9999_9999_1122_3344);
        chk("coll1_rdata", rdata_a, 32'h89AB_CDEF);
        fork
            axi_write(16'h0014, 32'h8888_8888, 4'hF, 0, 0, bresp_a, hs_w, b_cy);
            axi_read(16'h000C, rdata_a, rresp_a, hs_r, r_cy);
        join
        #2;
        chk("coll2_read_first", ren_cyc < wen_cyc, 1'b1);
        chk("coll2_wdata", wen_data, 64'h8888_8888_1122_3344);
        chk("coll2_rdata", rdata_a, 32'h0123_4567);

        // Reset while the read is waiting for data.
        m0 = ren_cnt;
        @(negedge clk);
        s_axil_arvalid = 1'b1;
        s_axil_araddr  = 16'h0008;
        #1;
        chk("rstrd_arready", s_axil_arready, 1'b1);
        @(negedge clk);
        s_axil_arvalid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rstrd_valid", {s_axil_bvalid, s_axil_rvalid}, 2'b00);
        chk("rstrd_ready", {s_axil_awready, s_axil_wready, s_axil_arready}, 3'b111);
        chk("rstrd_addrs", {o_reg_waddr, o_reg_raddr}, 32'h0);
        chk("rstrd_wdata", o_reg_wdata, 64'h0);
        chk("rstrd_rdata_resp", {s_axil_rdata, s_axil_bresp, s_axil_rresp}, 36'h0);
        rv_seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (s_axil_rvalid) rv_seen++;
        end
        chk("rstrd_no_rvalid", rv_seen, 0);
        chk("rstrd_one_ren", ren_cnt, m0 + 1);
        axi_read(16'h000C, rdata_a, rresp_a, hs_r, r_cy);
        #2;
        chk("rstrd_next_data", rdata_a, 32'h0123_4567);
        chk("rstrd_next_resp", rresp_a, OKAY);
        chk("rstrd_next_ren", ren_cnt, m0 + 2);
        chk("rstrd_next_latency", r_cy - hs_r, 3);

        chk("pulse_rules", pulse_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
